// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the RV32I fetch stage
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} fetch_state_e;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {instr,pc} buffer with flush; head holds its value once drained
module fetch_fifo import rv32_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t tail;
  logic [1:0] base;
  assign base = count - {1'b0, pop};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop && count == 2'd2) head <= tail;
      if (push && base == 2'd0) head <= din;
      if (push && base != 2'd0) tail <= din;
      count <= base + {1'b0, push};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch with 2-entry prefetch buffer and redirect handling
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_trap and halts fetch
module fetch_unit import rv32_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  input  logic               pc_src,
  input  logic [XLEN-1:0]    pc_target
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic             fetch_trap
`endif
);
  fetch_state_e state, state_d;
  fetch_entry_t head, din;
  logic [1:0] count;
  logic [XLEN-1:0] fetch_pc, req_addr, target;
  logic outstanding, primed, gnt, consume, redirect, push, misalign;
  // a new request may overlap only the cycle in which the previous one returns
  assign imem_req = state == FETCH && ({1'b0, count} + {2'b0, outstanding}) < 3'(FIFO_DEPTH)
                    && (!outstanding || imem_rvalid);
  assign imem_addr = fetch_pc;
  assign gnt = imem_req & imem_gnt;
  assign instr_valid = state == FETCH && count != 2'd0;
  assign consume = instr_valid & instr_ready;
  assign redirect = consume & pc_src;
  assign push = state == FETCH && imem_rvalid && outstanding && !redirect;
  assign target = {pc_target[XLEN-1:2], 2'b00};
  assign din = '{instr: imem_rdata, pc: req_addr};
  assign instr = head.instr;
  assign pc = head.pc;
  assign pc_plus4 = primed ? head.pc + 32'd4 : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap;
  assign misalign = redirect && pc_target[1:0] != 2'b00;
  assign fetch_trap = trap;
  always_ff @(posedge clk or posedge reset)
    if (reset) trap <= 1'b0;
    else trap <= trap | misalign;
`else
  logic unused_target_lsb;
  assign misalign = 1'b0;
  assign unused_target_lsb = ^pc_target[1:0];
`endif
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? FETCH
            : state == FETCH && misalign ? HALT
            : state == FETCH && redirect && (gnt || (outstanding && !imem_rvalid)) ? DRAIN
            : state == DRAIN && imem_rvalid ? FETCH
            : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      req_addr    <= '0;
      outstanding <= 1'b0;
      primed      <= 1'b0;
    end else begin
      state       <= state_d;
      fetch_pc    <= redirect ? target : gnt ? fetch_pc + 32'd4 : fetch_pc;
      req_addr    <= gnt ? fetch_pc : req_addr;
      outstanding <= gnt ? 1'b1 : imem_rvalid ? 1'b0 : outstanding;
      primed      <= primed | push;
    end
  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (consume),
    .din   (din),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a one-cycle-latency imem responder
module tb_fetch_unit;
  logic clk, reset;
  logic imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, pc_src;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, pc_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_trap;
`endif
  logic resp_en;
  logic [31:0] q[$];
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_src      (pc_src),
    .pc_target   (pc_target)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_trap (fetch_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory returns rdata = addr + 0x1000_0000 one cycle after grant, gated by resp_en
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) q.delete();
      else begin
        if (imem_rvalid && q.size() != 0) q.delete(0);
        if (imem_req && imem_gnt) q.push_back(imem_addr);
      end
      @(posedge clk);
      #1;
      imem_rvalid = resp_en && q.size() != 0;
      imem_rdata = q.size() != 0 ? q[0] + 32'h1000_0000 : '0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b0; pc_src = 1'b0; pc_target = '0; imem_gnt = 1'b1; resp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc4", pc_plus4, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    reset = 1'b0;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t1_req0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_req4", {31'b0, imem_req}, 32'd1);
    chk("t1_nvalid", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc4", pc_plus4, 32'h4);
    chk("t1_instr", instr, 32'h1000_0000);
    tick();
    chk("t2_credit", {31'b0, imem_req}, 32'd0);
    chk("t2_hold", pc, 32'h0);
    tick(); instr_ready = 1'b1;
    chk("t2_pop0", pc, 32'h0);
    tick();
    chk("t2_pop4", pc, 32'h4);
    chk("t2_instr4", instr, 32'h1000_0004);
    chk("t2_resume", {31'b0, imem_req}, 32'd1);
    chk("t2_addr8", imem_addr, 32'h8);
    tick(); instr_ready = 1'b0; resp_en = 1'b0;
    chk("t3_empty", {31'b0, instr_valid}, 32'd0);
    chk("t3_addrc", imem_addr, 32'hC);
    tick();
    chk("t3_pc8", pc, 32'h8);
    chk("t3_req_c_inflight", {31'b0, imem_req}, 32'd0);
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h100;
    tick(); instr_ready = 1'b0; pc_src = 1'b0; resp_en = 1'b1;
    chk("t3_drain_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_drain_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t3_stale_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_stale_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t3_req_tgt", {31'b0, imem_req}, 32'd1);
    chk("t3_addr_tgt", imem_addr, 32'h100);
    tick();
    chk("t3_wait", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t3_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", instr, 32'h1000_0100);
    tick(); instr_ready = 1'b1;
    tick();
    chk("t4g_pc", pc, 32'h104);
    chk("t4g_req", {31'b0, imem_req}, 32'd1);
    chk("t4g_addr", imem_addr, 32'h108);
    pc_src = 1'b1; pc_target = 32'h200;
    tick(); instr_ready = 1'b0; pc_src = 1'b0;
    chk("t4g_drain_valid", {31'b0, instr_valid}, 32'd0);
    chk("t4g_drain_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t4g_addr_tgt", imem_addr, 32'h200);
    tick();
    tick();
    chk("t4g_valid", {31'b0, instr_valid}, 32'd1);
    chk("t4g_pc", pc, 32'h200);
    chk("t4g_instr", instr, 32'h1000_0200);
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h300;
    tick(); instr_ready = 1'b0; pc_src = 1'b0;
    chk("t4r_nvalid", {31'b0, instr_valid}, 32'd0);
    chk("t4r_req", {31'b0, imem_req}, 32'd1);
    chk("t4r_addr", imem_addr, 32'h300);
    tick();
    chk("t4r_nstale", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t4r_valid", {31'b0, instr_valid}, 32'd1);
    chk("t4r_pc", pc, 32'h300);
    chk("t4r_instr", instr, 32'h1000_0300);
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'hFFFF_FFF8;
    tick(); instr_ready = 1'b0; pc_src = 1'b0;
    chk("t5_addr_fff8", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("t5_addr_fffc", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_pc_fff8", pc, 32'hFFFF_FFF8);
    chk("t5_pc4_fffc", pc_plus4, 32'hFFFF_FFFC);
    tick();
    chk("t5_addr_wrap", imem_addr, 32'h0);
    chk("t5_full_req", {31'b0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    tick(); instr_ready = 1'b0;
    chk("t5_pc_fffc", pc, 32'hFFFF_FFFC);
    chk("t5_pc4_wrap", pc_plus4, 32'h0);
    chk("t5_req_wrap", {31'b0, imem_req}, 32'd1);
    tick();
    tick();
    chk("t6_pre_pc", pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h102;
    tick(); instr_ready = 1'b0; pc_src = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_trap", {31'b0, fetch_trap}, 32'd1);
    chk("t6_halt_req", {31'b0, imem_req}, 32'd0);
    chk("t6_halt_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    tick();
    chk("t6_trap_sticky", {31'b0, fetch_trap}, 32'd1);
    chk("t6_halt_req2", {31'b0, imem_req}, 32'd0);
`else
    chk("t6_req", {31'b0, imem_req}, 32'd1);
    chk("t6_addr_masked", imem_addr, 32'h100);
    tick();
    tick();
    chk("t6_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_pc", pc, 32'h100);
`endif
    #1 reset = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mrst_pc", pc, 32'd0);
    chk("mrst_pc4", pc_plus4, 32'd0);
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mrst_trap", {31'b0, fetch_trap}, 32'd0);
`endif
    tick(); reset = 1'b0;
    tick();
    chk("mrst_restart_req", {31'b0, imem_req}, 32'd1);
    chk("mrst_restart_addr", imem_addr, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
